// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU slice-array sequencer: decode, latch, settle, flags (option: ALU_EARLY_DONE_EN)
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       set_flags,
    output logic       busy,
    output logic       done,
    output logic       result_we,
    output logic       inversion_OP1,
    output logic       select_OP2_to_A,
    output logic       select_OP2_to_A_inv,
    output logic       select_OP2_to_B,
    output logic       select_OP2_to_B_inv,
    output logic       en_carry,
    output logic       carry_in,
    output logic       OP1_latch_n,
    output logic       OP1_latch_p,
    output logic       OP2_latch_n,
    output logic       OP2_latch_p,
    input  logic       alu_msb,
    input  logic       alu_zero,
    input  logic       alu_n_carry,
    input  logic       alu_overflow,
    output logic [3:0] flags
);

    typedef enum logic [1:0] {IDLE, LATCH, EVAL, FLAGS} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] op_q;
    logic       sf_q;
    logic       latch_open;
    logic [5:0] ctrl_q;
    logic [5:0] ctrl_d;
    logic       cin_d;
    logic       op_is_logic;

    // Carry-using ops (ADC/SBC/RSC) take the C flag as it stands at acceptance.
    always_comb begin
        ctrl_d = 6'b000000;
        cin_d  = 1'b0;
        case (opcode)
            4'd0, 4'd8:  ctrl_d = 6'b010000;
            4'd1, 4'd9:  ctrl_d = 6'b010100;
            4'd2, 4'd10: begin ctrl_d = 6'b001011; cin_d = 1'b1;     end
            4'd3:        begin ctrl_d = 6'b110101; cin_d = 1'b1;     end
            4'd4, 4'd11: ctrl_d = 6'b010101;
            4'd5:        begin ctrl_d = 6'b010101; cin_d = flags[1]; end
            4'd6:        begin ctrl_d = 6'b001011; cin_d = flags[1]; end
            4'd7:        begin ctrl_d = 6'b110101; cin_d = flags[1]; end
            4'd12:       ctrl_d = 6'b000100;
            4'd13:       ctrl_d = 6'b100100;
            4'd14:       ctrl_d = 6'b001000;
            default:     ctrl_d = 6'b100010;
        endcase
    end

    assign op_is_logic = (op_q[3:1] == 3'b000) || (op_q[3:1] == 3'b100) || (op_q[3:2] == 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_q       <= 4'd0;
            sf_q       <= 1'b0;
            ctrl_q     <= 6'b000000;
            carry_in   <= 1'b0;
            latch_open <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_we  <= 1'b0;
            flags      <= 4'b0000;
        end else begin
            done      <= 1'b0;
            result_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= opcode;
                        sf_q       <= set_flags;
                        ctrl_q     <= ctrl_d;
                        carry_in   <= cin_d;
                        latch_open <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LATCH;
                    end
                end
                LATCH: begin
                    latch_open <= 1'b0;
`ifdef ALU_EARLY_DONE_EN
                    cnt        <= ctrl_q[0] ? SETTLE_LOAD : 4'd0;
`else
                    cnt        <= SETTLE_LOAD;
`endif
                    state      <= EVAL;
                end
                EVAL: begin
                    if (cnt == 4'd0) begin
                        state <= FLAGS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    if (sf_q) begin
                        flags[3] <= alu_msb;
                        flags[2] <= alu_zero;
                        if (!op_is_logic) begin
                            flags[1] <= ~alu_n_carry;
                            flags[0] <= alu_overflow;
                        end
                    end
                    done      <= 1'b1;
                    result_we <= (op_q[3:2] != 2'b10);
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign {inversion_OP1, select_OP2_to_A, select_OP2_to_A_inv,
            select_OP2_to_B, select_OP2_to_B_inv, en_carry} = ctrl_q;

    assign OP1_latch_p = latch_open;
    assign OP2_latch_p = latch_open;
    assign OP1_latch_n = ~latch_open;
    assign OP2_latch_n = ~latch_open;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed vector bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam int SETTLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] opcode;
    logic       set_flags;
    logic       busy, done, result_we;
    logic       inversion_OP1, select_OP2_to_A, select_OP2_to_A_inv;
    logic       select_OP2_to_B, select_OP2_to_B_inv, en_carry, carry_in;
    logic       OP1_latch_n, OP1_latch_p, OP2_latch_n, OP2_latch_p;
    logic       alu_msb, alu_zero, alu_n_carry, alu_overflow;
    logic [3:0] flags;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .set_flags(set_flags),
        .busy(busy), .done(done), .result_we(result_we),
        .inversion_OP1(inversion_OP1), .select_OP2_to_A(select_OP2_to_A),
        .select_OP2_to_A_inv(select_OP2_to_A_inv), .select_OP2_to_B(select_OP2_to_B),
        .select_OP2_to_B_inv(select_OP2_to_B_inv), .en_carry(en_carry), .carry_in(carry_in),
        .OP1_latch_n(OP1_latch_n), .OP1_latch_p(OP1_latch_p),
        .OP2_latch_n(OP2_latch_n), .OP2_latch_p(OP2_latch_p),
        .alu_msb(alu_msb), .alu_zero(alu_zero), .alu_n_carry(alu_n_carry),
        .alu_overflow(alu_overflow), .flags(flags)
    );

    typedef struct {
        logic [3:0] op;
        logic       sf;
        logic [3:0] alu;     // {msb, zero, n_carry, overflow}
        logic [5:0] ctrl;
        logic       cin;
        logic [3:0] flg;
        logic       we;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [5:0] ctrl_now();
        return {inversion_OP1, select_OP2_to_A, select_OP2_to_A_inv,
                select_OP2_to_B, select_OP2_to_B_inv, en_carry};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int exp_lat;
        exp_lat = SETTLE + 3;
`ifdef ALU_EARLY_DONE_EN
        if (!v.ctrl[0]) exp_lat = 4;
`endif
        @(negedge clk);
        opcode = v.op; set_flags = v.sf;
        {alu_msb, alu_zero, alu_n_carry, alu_overflow} = v.alu;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("v%0d latch_phase", idx),
            {busy, OP1_latch_p, OP1_latch_n, OP2_latch_p, OP2_latch_n}, 5'b11010);
        chk($sformatf("v%0d ctrl_cin", idx), {ctrl_now(), carry_in}, {v.ctrl, v.cin});
        lat = 1;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, exp_lat);
        chk($sformatf("v%0d flags_we_busy", idx), {flags, result_we, busy}, {v.flg, v.we, 1'b0});
        @(posedge clk); #1;
        chk($sformatf("v%0d done_pulse", idx), {done, result_we}, 2'b00);
    endtask

    initial begin
        int d1, d2, k;
        logic saw;
        vecs[0]  = '{4'd4,  1'b1, 4'b1001, 6'b010101, 1'b0, 4'b1011, 1'b1}; // ADD
        vecs[1]  = '{4'd10, 1'b1, 4'b0100, 6'b001011, 1'b1, 4'b0110, 1'b0}; // CMP
        vecs[2]  = '{4'd5,  1'b1, 4'b0010, 6'b010101, 1'b1, 4'b0000, 1'b1}; // ADC C=1
        vecs[3]  = '{4'd5,  1'b0, 4'b1001, 6'b010101, 1'b0, 4'b0000, 1'b1}; // ADC C=0
        vecs[4]  = '{4'd2,  1'b1, 4'b0100, 6'b001011, 1'b1, 4'b0110, 1'b1}; // SUB
        vecs[5]  = '{4'd12, 1'b1, 4'b0011, 6'b000100, 1'b0, 4'b0010, 1'b1}; // ORR
        vecs[6]  = '{4'd8,  1'b1, 4'b1000, 6'b010000, 1'b0, 4'b1010, 1'b0}; // TST
        vecs[7]  = '{4'd7,  1'b1, 4'b0011, 6'b110101, 1'b1, 4'b0001, 1'b1}; // RSC C=1
        vecs[8]  = '{4'd6,  1'b0, 4'b1100, 6'b001011, 1'b0, 4'b0001, 1'b1}; // SBC C=0
        vecs[9]  = '{4'd15, 1'b1, 4'b1000, 6'b100010, 1'b0, 4'b1001, 1'b1}; // MVN
        vecs[10] = '{4'd14, 1'b0, 4'b0100, 6'b001000, 1'b0, 4'b1001, 1'b1}; // BIC
        vecs[11] = '{4'd13, 1'b1, 4'b0100, 6'b100100, 1'b0, 4'b0101, 1'b1}; // MOV
        vecs[12] = '{4'd1,  1'b1, 4'b0000, 6'b010100, 1'b0, 4'b0001, 1'b1}; // EOR
        vecs[13] = '{4'd9,  1'b1, 4'b0100, 6'b010100, 1'b0, 4'b0101, 1'b0}; // TEQ
        vecs[14] = '{4'd3,  1'b1, 4'b1010, 6'b110101, 1'b1, 4'b1000, 1'b1}; // RSB
        vecs[15] = '{4'd11, 1'b1, 4'b0001, 6'b010101, 1'b0, 4'b0011, 1'b0}; // CMN
        vecs[16] = '{4'd0,  1'b1, 4'b0100, 6'b010000, 1'b0, 4'b0111, 1'b1}; // AND

        rst = 1'b1; start = 1'b0; opcode = 4'd0; set_flags = 1'b0;
        {alu_msb, alu_zero, alu_n_carry, alu_overflow} = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_status", {busy, done, result_we, flags}, 7'b0);
        chk("reset_ctrl", {ctrl_now(), carry_in}, 7'b0);
        chk("reset_latches", {OP1_latch_p, OP1_latch_n, OP2_latch_p, OP2_latch_n}, 4'b0101);

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Reset in the middle of EVAL: everything drops at once, no done afterwards.
        @(negedge clk);
        opcode = 4'd4; set_flags = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        chk("midreset_status", {busy, flags}, 5'b0);
        chk("midreset_latches", {OP1_latch_p, OP1_latch_n, OP2_latch_p, OP2_latch_n}, 4'b0101);
        @(negedge clk); rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        chk("midreset_no_done", saw, 1'b0);

        // start held high: accepted only in IDLE, including on the done cycle.
        @(negedge clk);
        opcode = 4'd4; set_flags = 1'b0; start = 1'b1;
        d1 = -1; d2 = -1;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == 8) chk("b2b_accept_on_done", busy, 1'b1);
        end
        start = 1'b0;
        chk("b2b_first_done", d1, SETTLE + 3);
        chk("b2b_spacing", d2 - d1, SETTLE + 3);
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
